// File: rtl/ddr3_pkg.sv
// Shared definitions for the DDR3 controller blocks: command encodings,
// clock-period based timing constants and the refresh scheduler state type.
package ddr3_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_MRS = 4'b0000;

  localparam int CLK_PERIOD_PS = 5000;

  // Rounds up so a converted timing is never shorter than the datasheet value.
  function automatic int ns_to_cycles(input int ns);
    return (ns * 1000 + CLK_PERIOD_PS - 1) / CLK_PERIOD_PS;
  endfunction

  localparam int TREFI_NS = 7800;
  localparam int TRP_NS   = 15;
  localparam int TRFC_NS  = 110;

  localparam int TREFI_CYCLES_DEF = ns_to_cycles(TREFI_NS);
  localparam int TRP_CYCLES_DEF   = ns_to_cycles(TRP_NS);
  localparam int TRFC_CYCLES_DEF  = ns_to_cycles(TRFC_NS);

  typedef enum logic [2:0] {
    RS_IDLE,
    RS_PREA,
    RS_WAIT_RP,
    RS_REF,
    RS_WAIT_RFC
  } refresh_state_t;

endpackage

// File: rtl/ddr3_delay_timer.sv
// Loadable down-counter used for command-to-command spacing (tRP, tRFC, ...).
// Counts down to zero and holds there; o_zero flags the expired state.
module ddr3_delay_timer #(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count <= '0;
    end else if (i_load) begin
      count <= i_load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign o_zero = (count == '0);

endmodule

// File: rtl/ddr3_refresh_scheduler.sv
// Autonomous DDR3 refresh scheduler: tracks tREFI, accumulates refresh debt and,
// when granted the bus, issues PREA followed by a burst of REF commands.
module ddr3_refresh_scheduler
  import ddr3_pkg::*;
#(
  parameter int TREFI_CYCLES = 1560,
  parameter int TRP_CYCLES   = 3,
  parameter int TRFC_CYCLES  = 22,
  parameter int MAX_POSTPONE = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_init_done,
  input  logic                                i_gnt,
  output logic                                o_req,
  output logic                                o_urgent,
  output logic                                o_busy,
  output logic [3:0]                          o_cmd,
  output logic                                o_a10,
  output logic [$clog2(MAX_POSTPONE+2)-1:0]   o_debt,
  output logic                                o_overflow
);

  localparam int DEBT_W = $clog2(MAX_POSTPONE + 2);
  localparam int CNT_W  = $clog2(TREFI_CYCLES + 1);
  localparam int T_MAX  = (TRP_CYCLES > TRFC_CYCLES) ? TRP_CYCLES : TRFC_CYCLES;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  localparam logic [DEBT_W-1:0] DEBT_SAT    = DEBT_W'(MAX_POSTPONE + 1);
  localparam logic [DEBT_W-1:0] DEBT_URGENT = DEBT_W'(MAX_POSTPONE);
  localparam logic [CNT_W-1:0]  TREFI_LAST  = CNT_W'(TREFI_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TRP_LOAD    = TMR_W'(TRP_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TRFC_LOAD   = TMR_W'(TRFC_CYCLES - 1);

  refresh_state_t    state;
  logic [CNT_W-1:0]  trefi_cnt;
  logic [DEBT_W-1:0] debt;
  logic              tick;
  logic              ref_issue;
  logic [DEBT_W-1:0] debt_after_ref;
  logic              timer_zero;
  logic              timer_load;
  logic [TMR_W-1:0]  timer_value;
  logic              start_seq;
  logic              rp_done;
  logic              rfc_done;
  logic              burst_more;

  assign tick           = i_init_done && (trefi_cnt == TREFI_LAST);
  assign ref_issue      = (state == RS_REF);
  assign debt_after_ref = debt - DEBT_W'(ref_issue);

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_init_done) begin
      trefi_cnt <= '0;
    end else if (tick) begin
      trefi_cnt <= '0;
    end else begin
      trefi_cnt <= trefi_cnt + CNT_W'(1);
    end
  end

  // A tick and a REF in the same cycle cancel; only an uncancelled tick at
  // saturation is lost and flagged.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      debt       <= '0;
      o_overflow <= 1'b0;
    end else begin
      case ({tick, ref_issue})
        2'b10: begin
          if (debt == DEBT_SAT) begin
            o_overflow <= 1'b1;
          end else begin
            debt <= debt + DEBT_W'(1);
          end
        end
        2'b01:   debt <= debt - DEBT_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: every always_comb output gets a value before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    start_seq   = 1'b0;
    rp_done     = 1'b0;
    rfc_done    = 1'b0;
    burst_more  = 1'b0;
    timer_load  = 1'b0;
    timer_value = TRFC_LOAD;
    start_seq   = (state == RS_IDLE) && i_gnt && (debt != '0);
    rp_done     = ((state == RS_PREA) || (state == RS_WAIT_RP)) && timer_zero;
    rfc_done    = ((state == RS_REF) || (state == RS_WAIT_RFC)) && timer_zero;
    burst_more  = rfc_done && i_gnt && (debt_after_ref != '0);
    timer_load  = start_seq || rp_done || burst_more;
    if (start_seq) begin
      timer_value = TRP_LOAD;
    end
  end

  ddr3_delay_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (timer_load),
    .i_load_value (timer_value),
    .o_zero       (timer_zero)
  );

  // Command outputs are registered alongside the state, so o_cmd always
  // shows the command belonging to the current state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= RS_IDLE;
      o_cmd  <= CMD_NOP;
      o_a10  <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      o_cmd <= CMD_NOP;
      o_a10 <= 1'b0;
      unique case (state)
        RS_IDLE: begin
          if (start_seq) begin
            state  <= RS_PREA;
            o_cmd  <= CMD_PRE;
            o_a10  <= 1'b1;
            o_busy <= 1'b1;
          end
        end
        RS_PREA, RS_WAIT_RP: begin
          if (rp_done) begin
            state <= RS_REF;
            o_cmd <= CMD_REF;
          end else begin
            state <= RS_WAIT_RP;
          end
        end
        RS_REF, RS_WAIT_RFC: begin
          if (burst_more) begin
            state <= RS_REF;
            o_cmd <= CMD_REF;
          end else if (rfc_done) begin
            state  <= RS_IDLE;
            o_busy <= 1'b0;
          end else begin
            state <= RS_WAIT_RFC;
          end
        end
        default: begin
          state  <= RS_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_debt   = debt;
  assign o_req    = (debt != '0);
  assign o_urgent = (debt >= DEBT_URGENT);

endmodule

// File: doc/ddr3_refresh_scheduler.md
# ddr3_refresh_scheduler

Autonomous refresh scheduler for the 4:1 DDR3 controller. Counts tREFI after initialization, accumulates refresh debt, requests the command bus from the main controller, and issues PRECHARGE-ALL followed by one or more REFRESH commands with tRP/tRFC spacing. Sits beside the init sequencer and read/write scheduler; its command output is muxed onto the PHY command slot while the controller grants it.

## Interface
- TREFI_CYCLES, 1560: controller clocks per tREFI (7.8 us at 5 ns).
- TRP_CYCLES, 3: clocks from PREA to REF, minimum 1.
- TRFC_CYCLES, 22: clocks from REF to the next command (1Gb: 110 ns), minimum 1.
- MAX_POSTPONE, 8: debt level at which the request becomes urgent.
- i_clk  in  1  controller clock; the only clock.
- i_rst  in  1  synchronous, active-high reset.
- i_init_done  in  1  init sequence complete; tREFI counting enabled.
- i_gnt  in  1  controller grants the command bus, with all banks quiescent.
- o_req  out  1  refresh debt is nonzero.
- o_urgent  out  1  debt >= MAX_POSTPONE; controller must grant at its next idle point.
- o_busy  out  1  sequence in progress; controller holds the command bus off.
- o_cmd  out  4  {cs_n, ras_n, cas_n, we_n}.
- o_a10  out  1  address bit 10: 1 on PREA, else 0.
- o_debt  out  4  outstanding refresh count, 0..MAX_POSTPONE+1.
- o_overflow  out  1  sticky error: tick arrived with debt already at MAX_POSTPONE+1.

## Operation
- Command encodings: NOP 4'b0111, PRE 4'b0010, REF 4'b0001.
- tREFI counter:
  - Held at 0 while i_init_done is low.
  - Otherwise counts 0..TREFI_CYCLES-1 and wraps to 0.
  - The wrap cycle is a tick.
- Debt on each tick:
  - Increments by 1, saturating at MAX_POSTPONE+1.
  - A tick at saturation sets o_overflow, which is cleared only by i_rst.
- States IDLE, PREA, WAIT_RP, REF, WAIT_RFC:
  - IDLE: o_cmd=NOP. If i_gnt & debt!=0, go to PREA. i_gnt with debt 0 is ignored.
  - PREA: one cycle, o_cmd=PRE, o_a10=1, load timer with TRP_CYCLES-1, go to WAIT_RP.
  - WAIT_RP: NOP until the timer reaches 0, then go to REF.
  - REF: one cycle, o_cmd=REF, debt decrements, load timer with TRFC_CYCLES-1, go to WAIT_RFC.
  - WAIT_RFC: NOP until the timer reaches 0. Then go to REF if (debt!=0 & i_gnt), else IDLE. The burst skips PREA because banks are still closed.
- i_gnt is sampled only in IDLE and on the last WAIT_RFC cycle. A drop mid-sequence is ignored.
- Tick and REF decrement in the same cycle: debt unchanged, no overflow.
- o_busy is 1 in every state except IDLE.
- o_req and o_urgent are combinational from the debt register.

## Timing
- Reset values:
  - o_cmd=NOP, o_a10=0, o_busy=0, o_req=0, o_urgent=0, o_debt=0, o_overflow=0.
  - Counter=0, state=IDLE.
- i_rst mid-sequence: the next cycle is IDLE with NOP and debt 0. No partial command is repeated.
- o_cmd and o_a10 are registered. With i_gnt sampled high in IDLE at cycle t:
  - PRE at t+1.
  - REF at t+1+TRP_CYCLES.
  - Next REF, if bursting, at t+1+TRP_CYCLES+TRFC_CYCLES.
- o_busy rises at t+1. It falls on the cycle the FSM re-enters IDLE, i.e. TRFC_CYCLES after the last REF.
- o_debt reflects a decrement the cycle after REF appears on o_cmd.
- First tick occurs TREFI_CYCLES cycles after i_init_done rises. o_req is high the next cycle.

## Structure
- Shared package ddr3_pkg holds the CMD_NOP/CMD_PRE/CMD_REF/CMD_ACT/CMD_RD/CMD_WR/CMD_MRS encodings and the ns-to-cycles timing constants used by all controller blocks.
- One sub-module, ddr3_delay_timer: a loadable down-counter with a load input, load value and a zero flag. It serves both tRP and tRFC and is reused by the main scheduler.
- Debt width is $clog2(MAX_POSTPONE+2).

## Test plan
- Reset, then i_init_done=1 with TREFI_CYCLES=16 and no grant:
  - o_req rises on cycle 17.
  - o_urgent rises at debt 8.
  - o_debt saturates at 9.
  - The next tick sets o_overflow.
- Debt 1, i_gnt pulsed at t, TRP=3, TRFC=22:
  - PRE with a10=1 at t+1.
  - REF at t+4.
  - o_busy falls at t+26.
  - o_debt=0.
- Debt 3, i_gnt held high: one PRE, then REFs at t+4, t+26 and t+48. o_debt reaches 0 and the FSM returns to IDLE.
- Tick coincident with REF at debt 2: o_debt stays 2, o_overflow stays 0.
- i_gnt dropped during WAIT_RP: the sequence completes normally. i_rst asserted in WAIT_RFC: the next cycle shows NOP, o_busy=0 and o_debt=0.
- i_gnt high with debt 0: o_cmd stays NOP and o_busy stays 0.
